// File: rtl/ysyx_22041071_mul_ctrl.sv
// ysyx_22041071_mul_ctrl
// Sequencing controller between the issue stage and a 64x64 multiplier.
// It latches one MUL/MULH/MULHSU/MULHU (or MULW) request, drives the
// multiplier while in CALC, then presents the selected result on the
// response port until it is consumed.
//
// Optional feature: define YSYX_22041071_MUL_PIPE_EN to add a HOLD state
// that re-registers the result (latency 3 instead of 2).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The controller holds resp_valid/resp_data/resp_tag stable
// until resp_ready, and req_ready never depends on req_valid. flush
// (and rst) block acceptance and cancel whatever is in flight.
module ysyx_22041071_mul_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  // request port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_word,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  input  logic [4:0]  req_tag,
  // response port
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [4:0]  resp_tag,
  // multiplier port
  output logic        m_valid,
  output logic        m_flush,
  output logic        m_mulw,
  output logic [1:0]  m_signed,
  output logic [63:0] m_src1,
  output logic [63:0] m_src2,
  input  logic        m_out_valid,
  input  logic [63:0] m_result_h,
  input  logic [63:0] m_result_l,
  // status
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
`ifdef YSYX_22041071_MUL_PIPE_EN
    S_HOLD = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic        word_q;
  logic [63:0] src1_q;
  logic [63:0] src2_q;
  logic [4:0]  tag_q;
  logic [63:0] res_q;
`ifdef YSYX_22041071_MUL_PIPE_EN
  logic [63:0] stage_q;
`endif

  logic        in_idle, in_calc, in_done;
  logic        accept;
  logic        load_res;
  logic [63:0] res_sel;
  logic [1:0]  sign_sel;

  assign in_idle = (state_q == S_IDLE);
  assign in_calc = (state_q == S_CALC);
  assign in_done = (state_q == S_DONE);

  // A new request may enter when idle, or when the current result is being
  // consumed this very cycle; flush and reset always win over acceptance.
  assign req_ready = (in_idle || (in_done && resp_ready)) && !flush && !rst;
  assign accept    = req_valid && req_ready;

  assign resp_valid = in_done && !flush && !rst;
  assign resp_data  = in_done ? res_q : 64'd0;
  assign resp_tag   = tag_q;
  assign busy       = !in_idle && !rst;
  assign dbg_state  = state_q;

  // Word ops and MUL/MULH treat both operands as signed; MULHSU signs only
  // src1; MULHU signs neither. Bit 1 qualifies src1, bit 0 qualifies src2.
  assign sign_sel = (word_q || op_q == OP_MUL || op_q == OP_MULH) ? 2'b11 :
                    (op_q == OP_MULHSU)                         ? 2'b10 :
                                                                  2'b00;

  assign m_valid  = in_calc && !rst;
  assign m_flush  = flush;
  assign m_mulw   = in_calc ? word_q   : 1'b0;
  assign m_signed = in_calc ? sign_sel : 2'b00;
  assign m_src1   = in_calc ? src1_q   : 64'd0;
  assign m_src2   = in_calc ? src2_q   : 64'd0;

  // MULW keeps the low word sign-extended; MUL keeps the low half; the
  // MULH variants keep the high half.
  assign res_sel = word_q          ? {{32{m_result_l[31]}}, m_result_l[31:0]} :
                   (op_q == OP_MUL) ? m_result_l : m_result_h;

  assign load_res = in_calc && m_out_valid && !flush;

  // Next-state logic; flush forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_CALC;
        S_CALC: begin
          if (m_out_valid) begin
`ifdef YSYX_22041071_MUL_PIPE_EN
            state_d = S_HOLD;
`else
            state_d = S_DONE;
`endif
          end
        end
`ifdef YSYX_22041071_MUL_PIPE_EN
        S_HOLD: state_d = S_DONE;
`endif
        S_DONE: begin
          if (resp_ready) state_d = accept ? S_CALC : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register plus request/result latches; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      word_q  <= 1'b0;
      src1_q  <= 64'd0;
      src2_q  <= 64'd0;
      tag_q   <= 5'd0;
      res_q   <= 64'd0;
`ifdef YSYX_22041071_MUL_PIPE_EN
      stage_q <= 64'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_op;
        word_q <= req_word;
        src1_q <= req_src1;
        src2_q <= req_src2;
        tag_q  <= req_tag;
      end
`ifdef YSYX_22041071_MUL_PIPE_EN
      if (load_res) stage_q <= res_sel;
      if ((state_q == S_HOLD) && !flush) res_q <= stage_q;
`else
      if (load_res) res_q <= res_sel;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_mul_ctrl.sv
// Directed testbench for ysyx_22041071_mul_ctrl. The bench contains a
// behavioural 64x64 multiplier that answers in the same cycle it is
// driven (m_out_valid can be held off through mul_go).
module tb_ysyx_22041071_mul_ctrl;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic        req_word = 1'b0;
  logic [63:0] req_src1 = 64'd0;
  logic [63:0] req_src2 = 64'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        m_valid, m_flush, m_mulw;
  logic [1:0]  m_signed;
  logic [63:0] m_src1, m_src2;
  logic        m_out_valid;
  logic [63:0] m_result_h, m_result_l;
  logic        busy;
  logic [1:0]  dbg_state;
  logic        mul_go = 1'b1;

  ysyx_22041071_mul_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_src1(req_src1), .req_src2(req_src2),
    .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .m_valid(m_valid), .m_flush(m_flush), .m_mulw(m_mulw),
    .m_signed(m_signed), .m_src1(m_src1), .m_src2(m_src2),
    .m_out_valid(m_out_valid), .m_result_h(m_result_h),
    .m_result_l(m_result_l),
    .busy(busy), .dbg_state(dbg_state)
  );

  // behavioural multiplier: m_signed[1] qualifies src1, m_signed[0] src2
  logic [127:0] mul_a, mul_b, mul_p;
  always_comb begin
    mul_a = m_signed[1] ? {{64{m_src1[63]}}, m_src1} : {64'd0, m_src1};
    mul_b = m_signed[0] ? {{64{m_src2[63]}}, m_src2} : {64'd0, m_src2};
    mul_p = mul_a * mul_b;
  end
  assign m_result_h  = mul_p[127:64];
  assign m_result_l  = mul_p[63:0];
  assign m_out_valid = m_valid && mul_go;

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present a request in an IDLE cycle, take it, leave the bench in CALC
  task automatic start_req(input logic [1:0] op, input logic word,
                           input logic [63:0] s1, input logic [63:0] s2,
                           input logic [4:0] tag);
    req_op = op; req_word = word; req_src1 = s1; req_src2 = s2; req_tag = tag;
    req_valid = 1'b1;
    #1;
    check("accept_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  // advance from CALC (multiplier answering) to DONE
  task automatic calc_to_done();
    tick();
`ifdef YSYX_22041071_MUL_PIPE_EN
    check("hold_state", dbg_state, ST_HOLD);
    check("hold_no_resp", resp_valid, 1'b0);
    tick();
`endif
  endtask

  task automatic drain();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    check("drain_idle", dbg_state, ST_IDLE);
    check("drain_busy", busy, 1'b0);
  endtask

  // one full operation with hand-computed expectations
  task automatic do_op(input string name, input logic [1:0] op, input logic word,
                       input logic [63:0] s1, input logic [63:0] s2, input logic [4:0] tag,
                       input logic [1:0] exp_sign);
    start_req(op, word, s1, s2, tag);
    check({name, "_calc_state"}, dbg_state, ST_CALC);
    check({name, "_m_valid"}, m_valid, 1'b1);
    check({name, "_m_signed"}, m_signed, exp_sign);
    check({name, "_m_mulw"}, m_mulw, word);
    check({name, "_m_src1"}, m_src1, s1);
    check({name, "_m_src2"}, m_src2, s2);
    check({name, "_data_zero_in_calc"}, resp_data, 64'd0);
    check({name, "_busy"}, busy, 1'b1);
    calc_to_done();
    check({name, "_resp_valid"}, resp_valid, 1'b1);
    check({name, "_data"}, resp_data, exp_q.pop_front());
    check({name, "_tag"}, resp_tag, tag);
    check({name, "_m_valid_off"}, m_valid, 1'b0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset behaviour
    tick();
    tick();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_state", dbg_state, ST_IDLE);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_data", resp_data, 64'd0);

    // MULH -1 * -1 = 1 -> high half 0
    exp_q.push_back(64'h0);
    do_op("mulh", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 2'b11);
    // MULHU (2^64-1)*2 -> high half 1
    exp_q.push_back(64'h1);
    do_op("mulhu", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 2'b00);
    // MULHSU -1 * 2 = -2 -> high half all ones
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    do_op("mulhsu", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 2'b10);
    // MULW 0x7FFFFFFF*2 = 0xFFFFFFFE -> sign-extended
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    do_op("mulw", 2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd6, 2'b11);
    // MUL low half: 0x1_0000_0003 * 5
    exp_q.push_back(64'h5_0000_000F);
    do_op("mul", 2'b00, 1'b0, 64'h1_0000_0003, 64'd5, 5'd7, 2'b11);

    // multiplier stalls: controller waits in CALC with operands held
    mul_go = 1'b0;
    start_req(2'b00, 1'b0, 64'd6, 64'd7, 5'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_state", dbg_state, ST_CALC);
      check("stall_src2", m_src2, 64'd7);
      check("stall_no_resp", resp_valid, 1'b0);
    end
    mul_go = 1'b1;
    calc_to_done();
    check("stall_data", resp_data, 64'd42);
    check("stall_tag", resp_tag, 5'd8);

    // response backpressure for 5 cycles while another request waits
    req_op = 2'b00; req_word = 1'b0; req_src1 = 64'd9; req_src2 = 64'd11; req_tag = 5'd12;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_resp_valid", resp_valid, 1'b1);
      check("bp_data", resp_data, 64'd42);
      check("bp_tag", resp_tag, 5'd8);
      check("bp_req_ready", req_ready, 1'b0);
      tick();
    end
    // back-to-back: consume and accept in the same cycle
    resp_ready = 1'b1;
    #1;
    check("b2b_ready", req_ready, 1'b1);
    tick();
    resp_ready = 1'b0;
    req_valid = 1'b0;
    #1;
    check("b2b_calc", dbg_state, ST_CALC);
    check("b2b_src1", m_src1, 64'd9);
    calc_to_done();
    check("b2b_data", resp_data, 64'd99);
    check("b2b_tag", resp_tag, 5'd12);
    drain();

    // flush during CALC: dropped, no response
    mul_go = 1'b0;
    start_req(2'b00, 1'b0, 64'd3, 64'd3, 5'd13);
    flush = 1'b1;
    #1;
    check("flush_m_flush", m_flush, 1'b1);
    check("flush_resp_valid", resp_valid, 1'b0);
    tick();
    flush = 1'b0;
    mul_go = 1'b1;
    #1;
    check("flush_idle", dbg_state, ST_IDLE);
    check("flush_busy", busy, 1'b0);
    check("flush_m_flush_off", m_flush, 1'b0);
    tick();
    check("flush_no_resp", resp_valid, 1'b0);

    // flush has priority over a request
    req_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_prio_ready", req_ready, 1'b0);
    tick();
    req_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_prio_idle", dbg_state, ST_IDLE);

    // next request after flush completes normally
    exp_q.push_back(64'd20);
    do_op("post_flush", 2'b00, 1'b0, 64'd4, 64'd5, 5'd14, 2'b11);

    // reset in DONE
    start_req(2'b00, 1'b0, 64'd2, 64'd2, 5'd15);
    calc_to_done();
    check("pre_rst_done", resp_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_done_resp_valid", resp_valid, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_done_state", dbg_state, ST_IDLE);
    check("rst_done_busy", busy, 1'b0);
    check("rst_done_resp_valid2", resp_valid, 1'b0);
    check("rst_done_tag", resp_tag, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_mul_ctrl.md
YSYX_22041071_MUL_CTRL -- requirements
Module: ysyx_22041071_mul_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, as fixed below.
REQ-002 SHALL provide `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL provide `flush`, input, 1 bit: cancels the in-flight operation.
REQ-005 SHALL provide the request port:
- `req_valid`, input, 1 bit: request present.
- `req_ready`, output, 1 bit: controller can accept a request.
- `req_op`, input, 2 bits: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_word`, input, 1 bit: 32-bit W variant, valid with MUL only.
- `req_src1`, input, 64 bits: multiplicand.
- `req_src2`, input, 64 bits: multiplier.
- `req_tag`, input, 5 bits: destination register index.
REQ-006 SHALL provide the response port:
- `resp_valid`, output, 1 bit: result present.
- `resp_ready`, input, 1 bit: consumer takes the result.
- `resp_data`, output, 64 bits: final result.
- `resp_tag`, output, 5 bits: tag of the result.
REQ-007 SHALL provide the multiplier port:
- `m_valid`, output, 1 bit.
- `m_flush`, output, 1 bit.
- `m_mulw`, output, 1 bit.
- `m_signed`, output, 2 bits.
- `m_src1`, output, 64 bits.
- `m_src2`, output, 64 bits.
- `m_out_valid`, input, 1 bit.
- `m_result_h`, input, 64 bits.
- `m_result_l`, input, 64 bits.
REQ-008 SHALL provide `busy`, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, CALC, HOLD (HOLD only with the REQ-023 macro defined) and DONE.
REQ-010 SHALL assert `req_ready` = (IDLE || (DONE && resp_ready)) && !flush.
REQ-011 SHALL, on accept (req_valid && req_ready), latch op, word, src1, src2 and tag, and enter CALC next cycle.
REQ-012 SHALL drive the multiplier from the latched values, in CALC only:
- `m_valid` = 1.
- `m_src1` and `m_src2` = the latched operands.
REQ-013 SHALL set `m_mulw` equal to the latched word bit.
REQ-014 SHALL set `m_signed`: MUL, MULH or word = 2'b11; MULHSU = 2'b10; MULHU = 2'b00.
REQ-015 SHALL, in CALC with `m_out_valid`=1, capture the selected result:
- MUL: `m_result_l`.
- MULH, MULHSU, MULHU: `m_result_h`.
- word: `m_result_l[31:0]` sign-extended to 64 bits.
REQ-016 SHALL remain in CALC, holding all latched values, while `m_out_valid`=0.
REQ-017 SHALL, in DONE, assert `resp_valid` = !flush, holding `resp_data` and `resp_tag` stable until resp_ready.
REQ-018 SHALL, in DONE with resp_ready, go to IDLE, or to CALC if a new request is accepted in the same cycle (back-to-back).
REQ-019 SHALL give a latency of 2 cycles from accept (cycle T) to `resp_valid` (T+2), with one operation in flight at most.
REQ-020 SHALL, on `flush`=1 in any state, enter IDLE next cycle, discard the result, and drive `m_flush`=flush combinationally; flush has priority over accept.
REQ-021 SHALL drive `resp_data` to 0 and `m_*` outputs to 0 when not in DONE and not in CALC, respectively.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, return to IDLE and clear all latched registers to 0. During reset: req_ready=0, resp_valid=0, busy=0, m_valid=0. rst overrides flush and any handshake, including mid-operation.

Configuration
REQ-023 SHALL use macro `YSYX_22041071_MUL_PIPE_EN`:
- Defined: CALC captures the result into a stage register, HOLD registers it again, then DONE; latency 3 cycles (T+3); flush in HOLD discards the result.
- Undefined: HOLD does not exist; latency 2 cycles.

Verification
REQ-024 SHALL cover: op=01, src1=src2=0xFFFF_FFFF_FFFF_FFFF, tag=3 -> resp_valid at T+2, data=0x0, tag=3.
REQ-025 SHALL cover: op=11, src1=0xFFFF_FFFF_FFFF_FFFF, src2=2 -> data=0x1; op=10, same operands -> data=0xFFFF_FFFF_FFFF_FFFF.
REQ-026 SHALL cover: op=00, word=1, src1=0x7FFF_FFFF, src2=2 -> data=0xFFFF_FFFF_FFFF_FFFE.
REQ-027 SHALL cover: resp_ready=0 for 5 cycles in DONE -> resp_valid, data and tag stable; req_ready=0 throughout.
REQ-028 SHALL cover: flush asserted in CALC -> IDLE next cycle, no resp_valid; the next request completes normally.
REQ-029 SHALL cover: rst pulsed in DONE -> resp_valid=0 next cycle, busy=0; with the macro defined, the REQ-024 case responds at T+3.
